// File: rtl/decode_stage_fwd_mc_pkg.sv
// Shared widths, NOP opcode and decode payload type for the decode/operand-fetch stage.
// Optional stall/backpressure counters in the top are enabled by DECODE_STALL_CNT_EN.
package decode_stage_fwd_mc_pkg;

  localparam int unsigned REG_W      = 64;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned MICRO_W    = 8;
  localparam int unsigned IMM_W      = 32;
  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned BIT_MODE_W = 2;

  localparam logic [MICRO_W-1:0] NOP_OP = MICRO_W'(0);

  typedef struct packed {
    logic [MICRO_W-1:0]    opcode;
    logic [REG_ADDR_W-1:0] dst_addr;
    logic [IMM_W-1:0]      imm;
    logic [BIT_MODE_W-1:0] bit_mode;
    logic                  efl_mode;
    logic [ADDR_W-1:0]     pc;
  } dec_payload_t;

endpackage

// File: rtl/decode_stage_fwd_mc_if.sv
// Upstream micro-op handshake and downstream registered payload of the decode stage.
// Optional stall/backpressure counters in the top are enabled by DECODE_STALL_CNT_EN.
interface decode_stage_fwd_mc_if #(
  parameter int unsigned N_SRC = 3
) ();
  import decode_stage_fwd_mc_pkg::*;

  logic                          in_valid;
  logic                          in_ready;
  logic [MICRO_W-1:0]            in_opcode;
  logic [N_SRC-1:0]              in_src_use;
  logic [N_SRC*REG_ADDR_W-1:0]   in_src_addr;
  logic [REG_ADDR_W-1:0]         in_dst_addr;
  logic [IMM_W-1:0]              in_imm;
  logic [BIT_MODE_W-1:0]         in_bit_mode;
  logic                          in_efl_mode;
  logic [ADDR_W-1:0]             in_pc;

  logic                          out_valid;
  logic                          out_ready;
  logic [MICRO_W-1:0]            out_opcode;
  logic [REG_ADDR_W-1:0]         out_dst_addr;
  logic [N_SRC*REG_ADDR_W-1:0]   out_src_addr;
  logic [IMM_W-1:0]              out_imm;
  logic [BIT_MODE_W-1:0]         out_bit_mode;
  logic                          out_efl_mode;
  logic [ADDR_W-1:0]             out_pc;
  logic [N_SRC*REG_W-1:0]        out_src_val;

  modport master (
    output in_valid, in_opcode, in_src_use, in_src_addr, in_dst_addr, in_imm,
           in_bit_mode, in_efl_mode, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_dst_addr, out_src_addr, out_imm,
           out_bit_mode, out_efl_mode, out_pc, out_src_val
  );

  modport slave (
    input  in_valid, in_opcode, in_src_use, in_src_addr, in_dst_addr, in_imm,
           in_bit_mode, in_efl_mode, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_dst_addr, out_src_addr, out_imm,
           out_bit_mode, out_efl_mode, out_pc, out_src_val
  );

endinterface

// File: rtl/fwd_operand_select.sv
// One operand slot: priority bypass mux (lowest index = youngest wins) over the GPR value,
// plus the pending flag of the winning entry.
module fwd_operand_select
  import decode_stage_fwd_mc_pkg::*;
#(
  parameter int unsigned N_FWD = 3
) (
  input  logic                        src_use,
  input  logic [REG_ADDR_W-1:0]       src_addr,
  input  logic [REG_W-1:0]            gpr_val,
  input  logic [N_FWD-1:0]            fwd_valid,
  input  logic [N_FWD-1:0]            fwd_pending,
  input  logic [N_FWD*REG_ADDR_W-1:0] fwd_addr,
  input  logic [N_FWD*REG_W-1:0]      fwd_data,
  output logic [REG_W-1:0]            src_val_c,
  output logic                        src_pend_c
);

  logic [REG_W-1:0] sel_val;
  logic             sel_pend;

  // Walk oldest to youngest so the youngest match overwrites, pending flag included.
  always_comb begin
    sel_val  = gpr_val;
    sel_pend = 1'b0;
    for (int k = int'(N_FWD) - 1; k >= 0; k--) begin
      if (fwd_valid[k] && (fwd_addr[k*REG_ADDR_W +: REG_ADDR_W] == src_addr)) begin
        sel_val  = fwd_data[k*REG_W +: REG_W];
        sel_pend = fwd_pending[k];
      end
    end
  end

  assign src_val_c  = src_use ? sel_val : '0;
  assign src_pend_c = src_use & sel_pend;

endmodule

// File: rtl/decode_stage_fwd_mc.sv
// Decode/operand-fetch stage: N_SRC bypassed operand reads, load-use interlock, held output register.
// Define DECODE_STALL_CNT_EN to add the stall_cycles / bp_cycles saturating counters.
module decode_stage_fwd_mc
  import decode_stage_fwd_mc_pkg::*;
#(
  parameter int unsigned N_SRC = 3,
  parameter int unsigned N_FWD = 3,
  parameter int unsigned REG_N = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  decode_stage_fwd_mc_if.slave        bus,
  input  logic [REG_N*REG_W-1:0]      gpr_flat,
  input  logic [N_FWD-1:0]            fwd_valid,
  input  logic [N_FWD-1:0]            fwd_pending,
  input  logic [N_FWD*REG_ADDR_W-1:0] fwd_addr,
  input  logic [N_FWD*REG_W-1:0]      fwd_data,
  input  logic                        flush,
  output logic                        hazard
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 bp_cycles
`endif
);

  localparam logic [0:0] ST_RUN       = 1'b0;
  localparam logic [0:0] ST_INTERLOCK = 1'b1;

  logic [REG_W-1:0]            gpr_c [REG_N];
  logic [N_SRC*REG_W-1:0]      slot_val_c;
  logic [N_SRC-1:0]            slot_pend_c;
  logic                        advance_c;

  logic                        out_valid_q, out_valid_d;
  dec_payload_t                pay_q, pay_d;
  logic [N_SRC*REG_ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [N_SRC*REG_W-1:0]      src_val_q, src_val_d;
  logic [0:0]                  state_q, state_d;

  for (genvar r = 0; r < REG_N; r++) begin : g_gpr
    assign gpr_c[r] = gpr_flat[r*REG_W +: REG_W];
  end

  for (genvar s = 0; s < N_SRC; s++) begin : g_slot
    logic [REG_ADDR_W-1:0] slot_addr;
    assign slot_addr = bus.in_src_addr[s*REG_ADDR_W +: REG_ADDR_W];

    fwd_operand_select #(.N_FWD(N_FWD)) u_sel (
      .src_use     (bus.in_src_use[s]),
      .src_addr    (slot_addr),
      .gpr_val     (gpr_c[slot_addr]),
      .fwd_valid   (fwd_valid),
      .fwd_pending (fwd_pending),
      .fwd_addr    (fwd_addr),
      .fwd_data    (fwd_data),
      .src_val_c   (slot_val_c[s*REG_W +: REG_W]),
      .src_pend_c  (slot_pend_c[s])
    );
  end

  assign hazard       = bus.in_valid & (|slot_pend_c);
  assign advance_c    = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = flush | (advance_c & ~hazard);

  // Output register: flush clears, backpressure holds, otherwise load or bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    pay_d       = pay_q;
    src_addr_d  = src_addr_q;
    src_val_d   = src_val_q;
    if (flush || (advance_c && !(bus.in_valid && !hazard))) begin
      out_valid_d  = 1'b0;
      pay_d        = '0;
      pay_d.opcode = NOP_OP;
      src_addr_d   = '0;
      src_val_d    = '0;
    end else if (advance_c) begin
      out_valid_d    = 1'b1;
      pay_d.opcode   = bus.in_opcode;
      pay_d.dst_addr = bus.in_dst_addr;
      pay_d.imm      = bus.in_imm;
      pay_d.bit_mode = bus.in_bit_mode;
      pay_d.efl_mode = bus.in_efl_mode;
      pay_d.pc       = bus.in_pc;
      src_addr_d     = bus.in_src_addr;
      src_val_d      = slot_val_c;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:       if (hazard && advance_c && !flush) state_d = ST_INTERLOCK;
      ST_INTERLOCK: if (!hazard || flush)              state_d = ST_RUN;
      default:                                         state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      pay_q       <= '0;
      src_addr_q  <= '0;
      src_val_q   <= '0;
      state_q     <= ST_RUN;
    end else begin
      out_valid_q <= out_valid_d;
      pay_q       <= pay_d;
      src_addr_q  <= src_addr_d;
      src_val_q   <= src_val_d;
      state_q     <= state_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_opcode   = pay_q.opcode;
  assign bus.out_dst_addr = pay_q.dst_addr;
  assign bus.out_imm      = pay_q.imm;
  assign bus.out_bit_mode = pay_q.bit_mode;
  assign bus.out_efl_mode = pay_q.efl_mode;
  assign bus.out_pc       = pay_q.pc;
  assign bus.out_src_addr = src_addr_q;
  assign bus.out_src_val  = src_val_q;

`ifdef DECODE_STALL_CNT_EN
  localparam int unsigned CNT_W = 32;

  logic [CNT_W-1:0] stall_q, stall_d, bp_q, bp_d;

  // Saturating counters; only rst clears them.
  always_comb begin
    stall_d = stall_q;
    bp_d    = bp_q;
    if ((state_q == ST_INTERLOCK) && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    if (out_valid_q && !bus.out_ready && (bp_q != '1)) bp_d = bp_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      bp_q    <= '0;
    end else begin
      stall_q <= stall_d;
      bp_q    <= bp_d;
    end
  end

  assign stall_cycles = stall_q;
  assign bp_cycles    = bp_q;
`endif

endmodule

// File: tb/tb_decode_stage_fwd_mc.sv
// Scoreboard bench for decode_stage_fwd_mc: directed vectors push expected micro-ops, a monitor pops on handoff.
// Counter checks are compiled in when DECODE_STALL_CNT_EN is defined.
module tb_decode_stage_fwd_mc;
  import decode_stage_fwd_mc_pkg::*;

  localparam int unsigned N_SRC = 3;
  localparam int unsigned N_FWD = 3;
  localparam int unsigned REG_N = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_stage_fwd_mc_if #(.N_SRC(N_SRC)) bus ();

  logic [REG_N*REG_W-1:0]      gpr_flat;
  logic [N_FWD-1:0]            fwd_valid;
  logic [N_FWD-1:0]            fwd_pending;
  logic [N_FWD*REG_ADDR_W-1:0] fwd_addr;
  logic [N_FWD*REG_W-1:0]      fwd_data;
  logic                        flush;
  logic                        hazard;
`ifdef DECODE_STALL_CNT_EN
  logic [31:0]                 stall_cycles;
  logic [31:0]                 bp_cycles;
`endif

  decode_stage_fwd_mc #(.N_SRC(N_SRC), .N_FWD(N_FWD), .REG_N(REG_N)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .gpr_flat    (gpr_flat),
    .fwd_valid   (fwd_valid),
    .fwd_pending (fwd_pending),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .flush       (flush),
    .hazard      (hazard)
`ifdef DECODE_STALL_CNT_EN
    ,
    .stall_cycles(stall_cycles),
    .bp_cycles   (bp_cycles)
`endif
  );

  typedef struct packed {
    logic [MICRO_W-1:0]          op;
    logic [REG_ADDR_W-1:0]       dst;
    logic [N_SRC*REG_ADDR_W-1:0] srca;
    logic [IMM_W-1:0]            imm;
    logic [BIT_MODE_W-1:0]       bm;
    logic                        efl;
    logic [ADDR_W-1:0]           pc;
    logic [N_SRC*REG_W-1:0]      vals;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every handoff must match the oldest expected micro-op.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_underflow: got opcode %0h want no transfer", bus.out_opcode);
      end else begin
        mon_e = sb.pop_front();
        chk("mon_payload",
            256'({bus.out_opcode, bus.out_dst_addr, bus.out_src_addr, bus.out_imm,
                  bus.out_bit_mode, bus.out_efl_mode, bus.out_pc}),
            256'({mon_e.op, mon_e.dst, mon_e.srca, mon_e.imm, mon_e.bm, mon_e.efl, mon_e.pc}));
        chk("mon_src_val", 256'(bus.out_src_val), 256'(mon_e.vals));
      end
    end
  end

  task automatic drive(input logic [7:0] op, input logic [2:0] use_m,
                       input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                       input logic [3:0] dst, input logic [63:0] pc);
    bus.in_valid    = 1'b1;
    bus.in_opcode   = op;
    bus.in_src_use  = use_m;
    bus.in_src_addr = {a2, a1, a0};
    bus.in_dst_addr = dst;
    bus.in_imm      = {24'hC0DE00, op};
    bus.in_bit_mode = op[1:0];
    bus.in_efl_mode = op[2];
    bus.in_pc       = pc;
  endtask

  task automatic set_fwd(input int k, input logic v, input logic p,
                         input logic [3:0] a, input logic [63:0] d);
    fwd_valid[k]            = v;
    fwd_pending[k]          = p;
    fwd_addr[k*4 +: 4]      = a;
    fwd_data[k*64 +: 64]    = d;
  endtask

  // Entered at posedge+1; waits (bounded) for in_ready, records expectation, returns at posedge+1.
  task automatic accept(input string name, input logic [191:0] vals, input bit push, input int max_wait);
    exp_t e;
    int   w;
    e.op   = bus.in_opcode;
    e.dst  = bus.in_dst_addr;
    e.srca = bus.in_src_addr;
    e.imm  = bus.in_imm;
    e.bm   = bus.in_bit_mode;
    e.efl  = bus.in_efl_mode;
    e.pc   = bus.in_pc;
    e.vals = vals;
    #1;
    w = 0;
    while (!bus.in_ready && w < max_wait) begin
      @(posedge clk);
      #2;
      w++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: in_ready=0 after %0d cycles want 1", name, w);
      bus.in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    fwd_valid    = '0;
    fwd_pending  = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b0;
    drive(8'h00, 3'b000, 4'd0, 4'd0, 4'd0, 4'd0, 64'h0);
    bus.in_valid = 1'b0;
    fwd_valid = '0; fwd_pending = '0; fwd_addr = '0; fwd_data = '0;
    for (int r = 0; r < int'(REG_N); r++) gpr_flat[r*64 +: 64] = 64'h100 + 64'(r);

    #12;
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_opcode", 256'(bus.out_opcode), 256'(0));
    chk("rst_src_val", 256'(bus.out_src_val), 256'(0));
    chk("rst_hazard", 256'(hazard), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Youngest of two matches wins; unused slot reads 0.
    set_fwd(0, 1'b1, 1'b0, 4'd5, 64'hBB);
    set_fwd(2, 1'b1, 1'b0, 4'd5, 64'hAA);
    drive(8'h11, 3'b011, 4'd2, 4'd5, 4'd7, 4'd1, 64'h1000);
    accept("t1", {64'h0, 64'hBB, 64'h102}, 1'b1, 4);
    chk("t1_lat_valid", 256'(bus.out_valid), 256'(1));
    chk("t1_lat_opcode", 256'(bus.out_opcode), 256'(8'h11));
    // Duplicate addresses resolve identically, back-to-back with the previous op.
    drive(8'h12, 3'b111, 4'd5, 4'd5, 4'd5, 4'd2, 64'h1004);
    accept("t2", {64'hBB, 64'hBB, 64'hBB}, 1'b1, 4);
    set_fwd(0, 1'b0, 1'b0, 4'd0, 64'h0);
    set_fwd(1, 1'b1, 1'b0, 4'd9, 64'hCC);
    set_fwd(2, 1'b1, 1'b0, 4'd9, 64'hDD);
    drive(8'h13, 3'b111, 4'd9, 4'd4, 4'd9, 4'd3, 64'h1008);
    accept("t3", {64'hCC, 64'h104, 64'hCC}, 1'b1, 4);
    idle(2);

    // Load-use: young pending match must not be masked by an older ready one.
    set_fwd(0, 1'b1, 1'b1, 4'd3, 64'h0);
    set_fwd(2, 1'b1, 1'b0, 4'd3, 64'hEE);
    drive(8'h21, 3'b010, 4'd0, 4'd3, 4'd0, 4'd4, 64'h2000);
    #1;
    chk("t4_hazard", 256'(hazard), 256'(1));
    chk("t4_in_ready", 256'(bus.in_ready), 256'(0));
    @(posedge clk); #1;
    chk("t4_bubble_valid", 256'(bus.out_valid), 256'(0));
    chk("t4_bubble_opcode", 256'(bus.out_opcode), 256'(0));
    chk("t4_state_interlock", 256'(dut.state_q), 256'(1));
    set_fwd(0, 1'b1, 1'b0, 4'd3, 64'h77);
    accept("t4", {64'h0, 64'h77, 64'h0}, 1'b1, 4);
    chk("t4_state_run", 256'(dut.state_q), 256'(0));
`ifdef DECODE_STALL_CNT_EN
    chk("t4_stall_cycles", 256'(stall_cycles), 256'(1));
`endif
    idle(2);

    // Pending entry on an unused slot causes no hazard.
    set_fwd(0, 1'b1, 1'b1, 4'd3, 64'h55);
    drive(8'h22, 3'b001, 4'd6, 4'd3, 4'd0, 4'd5, 64'h2004);
    #1;
    chk("t5_hazard", 256'(hazard), 256'(0));
    accept("t5", {64'h0, 64'h0, 64'h106}, 1'b1, 4);
    idle(2);

    // Backpressure holds the output register for four cycles, then drains in order.
    bus.out_ready = 1'b0;
    drive(8'h31, 3'b111, 4'd1, 4'd2, 4'd3, 4'd6, 64'h3000);
    accept("t6a", {64'h103, 64'h102, 64'h101}, 1'b1, 4);
    drive(8'h32, 3'b001, 4'd8, 4'd0, 4'd0, 4'd7, 64'h3004);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_hold_in_ready", 256'(bus.in_ready), 256'(0));
      chk("t6_hold_opcode", 256'(bus.out_opcode), 256'(8'h31));
      chk("t6_hold_src_val", 256'(bus.out_src_val), 256'({64'h103, 64'h102, 64'h101}));
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    accept("t6b", {64'h0, 64'h0, 64'h108}, 1'b1, 4);
`ifdef DECODE_STALL_CNT_EN
    chk("t6_bp_cycles", 256'(bp_cycles), 256'(4));
`endif
    drive(8'h33, 3'b100, 4'd0, 4'd0, 4'd15, 4'd8, 64'h3008);
    accept("t6c", {64'h10F, 64'h0, 64'h0}, 1'b1, 4);
    idle(2);

    // Flush beats hazard and backpressure; held op and the input are both dropped.
    bus.out_ready = 1'b0;
    drive(8'h41, 3'b001, 4'd1, 4'd0, 4'd0, 4'd9, 64'h4000);
    accept("t7a", {64'h0, 64'h0, 64'h101}, 1'b0, 4);
    set_fwd(0, 1'b1, 1'b1, 4'd3, 64'h0);
    drive(8'h42, 3'b001, 4'd3, 4'd0, 4'd0, 4'd10, 64'h4004);
    #1;
    chk("t7_hazard", 256'(hazard), 256'(1));
    chk("t7_in_ready", 256'(bus.in_ready), 256'(0));
    @(posedge clk); #1;
    chk("t7_held_opcode", 256'(bus.out_opcode), 256'(8'h41));
    flush = 1'b1;
    #1;
    chk("t7_flush_in_ready", 256'(bus.in_ready), 256'(1));
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("t7_flush_valid", 256'(bus.out_valid), 256'(0));
    chk("t7_flush_opcode", 256'(bus.out_opcode), 256'(0));
    chk("t7_flush_src_val", 256'(bus.out_src_val), 256'(0));
    chk("t7_flush_state", 256'(dut.state_q), 256'(0));
    bus.out_ready = 1'b1;
    idle(2);

    // Asynchronous reset drops the held op; first op after release issues in one cycle.
    drive(8'h51, 3'b111, 4'd1, 4'd1, 4'd1, 4'd11, 64'h5000);
    accept("t8a", {64'h101, 64'h101, 64'h101}, 1'b0, 4);
    #1;
    rst = 1'b1;
    #1;
    chk("t8_rst_valid", 256'(bus.out_valid), 256'(0));
    chk("t8_rst_opcode", 256'(bus.out_opcode), 256'(0));
    chk("t8_rst_src_val", 256'(bus.out_src_val), 256'(0));
    chk("t8_rst_pc", 256'(bus.out_pc), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    drive(8'h52, 3'b010, 4'd0, 4'd7, 4'd0, 4'd12, 64'h5004);
    accept("t8b", {64'h0, 64'h107, 64'h0}, 1'b1, 4);
    chk("t8_lat_valid", 256'(bus.out_valid), 256'(1));
    chk("t8_lat_opcode", 256'(bus.out_opcode), 256'(8'h52));
    idle(3);

    chk("sb_drain", 256'(sb.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage_fwd_mc.md
Name: decode_stage_fwd_mc

Overview:
Parametrised decode/operand-fetch stage that supersedes the fixed three-operand decode stage. It takes one micro-op per cycle from the decode queue over a valid/ready handshake and reads N_SRC source registers from the GPR file. Each operand is resolved through a prioritised N_FWD-entry bypass network. The stage detects load-use hazards, inserts bubbles for them, and holds its output register under downstream backpressure instead of zeroing it.

Parameters:
N_SRC, 3, number of source operand slots
N_FWD, 3, number of bypass sources; index 0 is the youngest (exe) and has the highest priority
REG_W, 64, register data width
REG_ADDR_W, 4, register address width
REG_N, 16, number of GPRs
MICRO_W, 8, micro-opcode width
IMM_W, 32, immediate width
ADDR_W, 64, PC width
BIT_MODE_W, 2, bit-mode field width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  upstream micro-op valid
in_ready  out  1  stage accepts the micro-op this cycle
in_opcode  in  MICRO_W  micro-opcode; 0 = nop
in_src_use  in  N_SRC  per-slot "operand is read" mask
in_src_addr  in  N_SRC*REG_ADDR_W  packed source addresses, slot 0 in the LSBs
in_dst_addr  in  REG_ADDR_W  destination address, passed through
in_imm  in  IMM_W  immediate
in_bit_mode  in  BIT_MODE_W  bit mode
in_efl_mode  in  1  EFLAGS mode
in_pc  in  ADDR_W  PC
gpr_flat  in  REG_N*REG_W  architectural register file, reg 0 in the LSBs
fwd_valid  in  N_FWD  bypass entry holds an in-flight write
fwd_pending  in  N_FWD  entry result not yet available (load in flight)
fwd_addr  in  N_FWD*REG_ADDR_W  bypass destination addresses
fwd_data  in  N_FWD*REG_W  bypass data
flush  in  1  squash
out_valid  out  1  output register holds a micro-op
out_ready  in  1  downstream accepts
out_opcode, out_dst_addr, out_src_addr, out_imm, out_bit_mode, out_efl_mode, out_pc  out  same widths as inputs  registered payload
out_src_val  out  N_SRC*REG_W  resolved operand values
hazard  out  1  combinational load-use interlock indicator

Behaviour:
- Reset: all outputs are 0 and state is RUN. Reset is asynchronous and active-high.
- Per-slot operand resolution (combinational):
  - Candidate entries satisfy fwd_valid[k] & fwd_addr[k]==src_addr.
  - The lowest matching k wins; with no match, the value is gpr_flat[src_addr].
  - Slots with in_src_use=0 resolve to 0 and never cause a hazard.
- hazard = in_valid & OR over used slots of (the winning entry has fwd_pending=1).
  - An older, non-pending match at a higher index must not mask a younger pending one.
- advance = ~out_valid | out_ready.
- in_ready = flush | (advance & ~hazard).
- Every clock edge, in priority order:
  1. flush: out_valid←0 and payload/values←0. The input is consumed and dropped.
  2. ~advance: all outputs hold unchanged, including out_src_val.
  3. in_valid & ~hazard: load payload and resolved values; out_valid←1.
  4. Otherwise: bubble. out_valid←0 and payload/values←0, so opcode 0 = nop.
- Latency: 1 cycle from accept to out_valid. Sustained throughput is 1 per cycle with no hazards.
- FSM, two states:
  - RUN → INTERLOCK when hazard & advance & ~flush.
  - INTERLOCK → RUN when ~hazard or flush.
  - The state drives only the optional counters and is otherwise informational.
- Simultaneous events:
  - Flush overrides hazard and backpressure.
  - A bypass entry becoming non-pending in the same cycle it is sampled is used that cycle.
  - Duplicate addresses across slots resolve independently and identically.
- Reset mid-operation drops any held micro-op immediately.

Optional Feature:
DECODE_STALL_CNT_EN
- Defined: adds 32-bit outputs stall_cycles (counts cycles in INTERLOCK) and bp_cycles (counts cycles with out_valid & ~out_ready).
  - Both saturate at 0xFFFFFFFF and are cleared by rst only, not by flush.
- Undefined: both ports and their logic are absent.

Decomposition:
- Shared package:
  - width constants (REG_W, REG_ADDR_W, MICRO_W, IMM_W, ADDR_W, BIT_MODE_W)
  - NOP opcode constant (0)
  - a typedef for the decode payload struct
- One sub-module, fwd_operand_select: a single slot's priority bypass mux plus its pending flag, instantiated N_SRC times in a generate loop.

Test Plan:
- Slot s used, addr 5; fwd[2] valid, addr 5, data 0xAA; fwd[0] valid, addr 5, data 0xBB; none pending → out_src_val slot s = 0xBB one cycle later.
- fwd[0] valid, addr 3, pending; slot t addr 3 used → hazard=1, in_ready=0, out_valid=0 bubble. Clear pending with data 0x77 next cycle → micro-op issues with 0x77, and stall_cycles=1 if DECODE_STALL_CNT_EN is defined.
- Same setup as above but in_src_use[t]=0 → no hazard; micro-op issues and slot t value = 0.
- Hold out_ready=0 for 4 cycles with in_valid=1 → outputs unchanged, in_ready=0. Release → back-to-back issue with no loss or duplication.
- Assert flush together with a hazard and out_ready=0 → next cycle out_valid=0, opcode=0, state=RUN.
- Assert rst mid-stream → all outputs go to 0 asynchronously. After release, the first accepted micro-op issues after 1 cycle.
